// File: rtl/game_control.sv
// game_control: control FSM for the game datapath.
// Runs init -> draw -> idle. From idle it performs one attack or one 1-px move
// per frame tick, each followed by a redraw. Buttons are synchronised, attack is
// edge-triggered, and a watchdog aborts to init if a *_done handshake stalls.
//
// Ports:
//   clock, resetn                         system clock, async active-low reset
//   btn_up/down/left/right/attack         raw active-high buttons (asynchronous)
//   init_done, idle_done, attack_done,
//   move_done, draw_done                  datapath handshakes
//   init, idle, attack, up, down,
//   left, right, draw                     one-hot datapath commands
//   state[2:0]                            current state code
//   err                                   sticky watchdog-abort flag
module game_control #(
    parameter int unsigned FRAME_DIV = 833334,
    parameter int unsigned TIMEOUT   = 200000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_attack,
    input  logic       init_done,
    input  logic       idle_done,
    input  logic       attack_done,
    input  logic       move_done,
    input  logic       draw_done,
    output logic       init,
    output logic       idle,
    output logic       attack,
    output logic       up,
    output logic       down,
    output logic       left,
    output logic       right,
    output logic       draw,
    output logic [2:0] state,
    output logic       err
);

    localparam int unsigned FW = $clog2(FRAME_DIV);
    localparam int unsigned WW = $clog2(TIMEOUT);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_DIV - 1);
    localparam logic [WW-1:0] WD_LAST    = WW'(TIMEOUT - 1);
    localparam int unsigned NB = 5;

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_DRAW   = 3'd1,
        S_IDLE   = 3'd2,
        S_ATTACK = 3'd3,
        S_UP     = 3'd4,
        S_DOWN   = 3'd5,
        S_LEFT   = 3'd6,
        S_RIGHT  = 3'd7
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [NB-1:0]   btn_meta;
    logic [NB-1:0]   btn_sync;
    logic            atk_prev;
    logic            atk_req;
    logic            atk_rise;
    logic            atk_clr;
    logic [FW-1:0]   frame_cnt;
    logic            frame_wrap;
    logic            tick_pend;
    logic            tick_clr;
    logic [WW-1:0]   wd_cnt;
    logic            wd_fire;
    logic            done_cur;

    // Synchronised button bits: {attack, right, left, down, up}
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            btn_meta <= '0;
            btn_sync <= '0;
            atk_prev <= 1'b0;
        end else begin
            btn_meta <= {btn_attack, btn_right, btn_left, btn_down, btn_up};
            btn_sync <= btn_meta;
            atk_prev <= btn_sync[4];
        end
    end

    assign atk_rise   = btn_sync[4] & ~atk_prev;
    assign frame_wrap = (frame_cnt == FRAME_LAST);

    // Next-state decode, handshake consumption and watchdog abort
    always_comb begin
        state_d  = state_q;
        tick_clr = 1'b0;
        atk_clr  = 1'b0;
        done_cur = 1'b0;
        wd_fire  = 1'b0;
        case (state_q)
            S_INIT: begin
                done_cur = init_done;
                if (init_done) state_d = S_DRAW;
            end
            S_DRAW: begin
                done_cur = draw_done;
                if (draw_done) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (idle_done && tick_pend) begin
                    tick_clr = 1'b1;
                    if (atk_req) begin
                        state_d = S_ATTACK;
                        atk_clr = 1'b1;
                    end else if (btn_sync[0]) begin
                        state_d = S_UP;
                    end else if (btn_sync[1]) begin
                        state_d = S_DOWN;
                    end else if (btn_sync[2]) begin
                        state_d = S_LEFT;
                    end else if (btn_sync[3]) begin
                        state_d = S_RIGHT;
                    end
                end
            end
            S_ATTACK: begin
                done_cur = attack_done;
                if (attack_done) state_d = S_DRAW;
            end
            S_UP, S_DOWN, S_LEFT, S_RIGHT: begin
                done_cur = move_done;
                if (move_done) state_d = S_DRAW;
            end
            default: state_d = S_INIT;
        endcase
        // A done arriving on the terminal count still wins over the abort
        if ((state_q != S_IDLE) && (wd_cnt == WD_LAST) && !done_cur) begin
            wd_fire  = 1'b1;
            state_d  = S_INIT;
            tick_clr = 1'b1;
            atk_clr  = 1'b1;
        end
    end

    // State register with registered one-hot command decode
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_INIT;
            init    <= 1'b1;
            draw    <= 1'b0;
            idle    <= 1'b0;
            attack  <= 1'b0;
            up      <= 1'b0;
            down    <= 1'b0;
            left    <= 1'b0;
            right   <= 1'b0;
        end else begin
            state_q <= state_d;
            init    <= (state_d == S_INIT);
            draw    <= (state_d == S_DRAW);
            idle    <= (state_d == S_IDLE);
            attack  <= (state_d == S_ATTACK);
            up      <= (state_d == S_UP);
            down    <= (state_d == S_DOWN);
            left    <= (state_d == S_LEFT);
            right   <= (state_d == S_RIGHT);
        end
    end

    assign state = state_q;

    // Frame tick, attack request, watchdog and sticky error; sets win over clears
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            frame_cnt <= '0;
            tick_pend <= 1'b0;
            atk_req   <= 1'b0;
            wd_cnt    <= '0;
            err       <= 1'b0;
        end else begin
            frame_cnt <= frame_wrap ? '0 : frame_cnt + FW'(1);

            if (frame_wrap)    tick_pend <= 1'b1;
            else if (tick_clr) tick_pend <= 1'b0;

            if (atk_rise)      atk_req <= 1'b1;
            else if (atk_clr)  atk_req <= 1'b0;

            if ((state_d != state_q) || (state_q == S_IDLE) || wd_fire)
                wd_cnt <= '0;
            else
                wd_cnt <= wd_cnt + WW'(1);

            if (wd_fire) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_game_control.sv
// tb_game_control: directed, cycle-exact bench for game_control with
// FRAME_DIV=8 and TIMEOUT=16. Cycle 0 is the first cycle after reset release.
module tb_game_control;

    logic       clock;
    logic       resetn;
    logic       btn_up, btn_down, btn_left, btn_right, btn_attack;
    logic       init_done, idle_done, attack_done, move_done, draw_done;
    logic       init, idle, attack, up, down, left, right, draw;
    logic [2:0] state;
    logic       err;
    logic [7:0] cmds;

    int total = 0;
    int bad   = 0;

    localparam int ST_INIT = 0, ST_DRAW = 1, ST_IDLE = 2, ST_ATTACK = 3,
                   ST_UP = 4, ST_LEFT = 6, ST_RIGHT = 7;

    game_control #(.FRAME_DIV(8), .TIMEOUT(16)) dut (
        .clock(clock), .resetn(resetn),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
        .btn_right(btn_right), .btn_attack(btn_attack),
        .init_done(init_done), .idle_done(idle_done), .attack_done(attack_done),
        .move_done(move_done), .draw_done(draw_done),
        .init(init), .idle(idle), .attack(attack), .up(up), .down(down),
        .left(left), .right(right), .draw(draw), .state(state), .err(err)
    );

    assign cmds = {right, left, down, up, attack, idle, draw, init};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic exp_st(input string tag, input int st);
        logic [7:0] oh;
        oh = 8'(1 << st);
        check({tag, "_state"}, 32'(state), 32'(st));
        check({tag, "_cmd"},   32'(cmds),  32'(oh));
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clr_done();
        init_done = 1'b0; attack_done = 1'b0; move_done = 1'b0; draw_done = 1'b0;
    endtask

    initial begin
        resetn = 1'b0;
        btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0; btn_attack = 1'b0;
        idle_done = 1'b0;
        clr_done();
        repeat (2) @(posedge clock);
        #1;
        exp_st("reset", ST_INIT);
        check("reset_err", 32'(err), 32'd0);

        // Boot: init_done at cycle 3, draw_done at cycle 6, up held throughout
        resetn = 1'b1;
        btn_up = 1'b1;
        for (int c = 0; c <= 3; c++) begin
            init_done = (c == 3);
            exp_st("boot_init", ST_INIT);
            step();
        end
        clr_done();
        for (int c = 4; c <= 6; c++) begin
            draw_done = (c == 6);
            exp_st("boot_draw", ST_DRAW);
            step();
        end
        clr_done();
        idle_done = 1'b1;
        for (int c = 7; c <= 8; c++) begin
            exp_st("boot_idle", ST_IDLE);
            step();
        end

        // Cycle 9: first move; foreign dones are ignored
        draw_done = 1'b1; attack_done = 1'b1;
        exp_st("up1", ST_UP);
        step();
        clr_done();
        move_done = 1'b1;
        exp_st("up1_ign", ST_UP);
        step();
        clr_done();
        draw_done = 1'b1;
        exp_st("up1_draw", ST_DRAW);
        step();
        clr_done();
        for (int c = 12; c <= 16; c++) begin
            exp_st("rate_idle", ST_IDLE);
            step();
        end

        // Cycle 17: second move one frame later
        move_done = 1'b1;
        exp_st("up2", ST_UP);
        step();
        clr_done();
        draw_done = 1'b1;
        exp_st("up2_draw", ST_DRAW);
        step();
        clr_done();

        // Attack + up together from cycle 19: attack has priority
        btn_attack = 1'b1;
        for (int c = 19; c <= 24; c++) begin
            exp_st("atk_idle", ST_IDLE);
            step();
        end
        attack_done = 1'b1;
        exp_st("atk", ST_ATTACK);
        step();
        clr_done();
        draw_done = 1'b1;
        exp_st("atk_draw", ST_DRAW);
        step();
        clr_done();
        for (int c = 27; c <= 32; c++) begin
            exp_st("hold_idle", ST_IDLE);
            step();
        end
        // Cycle 33: held attack gives no second attack; up follows
        move_done = 1'b1;
        btn_up = 1'b0; btn_attack = 1'b0; btn_left = 1'b1;
        exp_st("up3", ST_UP);
        step();
        clr_done();
        draw_done = 1'b1;
        exp_st("up3_draw", ST_DRAW);
        step();
        clr_done();
        for (int c = 35; c <= 40; c++) begin
            exp_st("left_idle", ST_IDLE);
            step();
        end

        // Cycles 41..56: stalled left move, watchdog fires into cycle 57
        for (int c = 41; c <= 56; c++) begin
            exp_st("left_stall", ST_LEFT);
            step();
        end
        btn_left = 1'b0; btn_right = 1'b1;
        init_done = 1'b1;
        exp_st("wd_init", ST_INIT);
        check("wd_err", 32'(err), 32'd1);
        step();
        clr_done();
        draw_done = 1'b1;
        exp_st("wd_draw", ST_DRAW);
        step();
        clr_done();
        // Pending tick from cycle 56 was discarded by the abort
        for (int c = 59; c <= 64; c++) begin
            if (c == 63) btn_attack = 1'b1;
            exp_st("wd_idle", ST_IDLE);
            step();
        end
        check("err_sticky", 32'(err), 32'd1);
        move_done = 1'b1;
        exp_st("right1", ST_RIGHT);
        step();
        clr_done();

        // Cycle 66: asynchronous reset in the middle of draw
        exp_st("pre_rst", ST_DRAW);
        check("pre_rst_err", 32'(err), 32'd1);
        #2 resetn = 1'b0;
        #1;
        exp_st("arst", ST_INIT);
        check("arst_err", 32'(err), 32'd0);
        btn_attack = 1'b0;
        step();
        resetn = 1'b1;

        // After release: no stale tick or attack; right held
        init_done = 1'b1;
        exp_st("r_init", ST_INIT);
        step();
        clr_done();
        draw_done = 1'b1;
        exp_st("r_draw", ST_DRAW);
        step();
        clr_done();
        for (int c = 2; c <= 8; c++) begin
            exp_st("r_idle", ST_IDLE);
            step();
        end
        exp_st("r_right", ST_RIGHT);
        check("r_err", 32'(err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
